arb_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a one-entry registered output stage and valid/ready handshakes on every port. It replaces a fixed 2:1 select where several producers share one consumer, for example instruction-fetch and load/store requests sharing a single memory port. Arbitration is round-robin or fixed-priority, chosen at elaboration. Output latency is one cycle.

---
 rtl/arb_mux_pkg.sv | 23 ++
 rtl/arb_mux_rr_arbiter.sv | 52 +++++
 rtl/arb_mux.sv | 68 ++++++
 tb/tb_arb_mux.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the N-way arbitrated multiplexer family.
// sel_width() is reused by any block that needs an index into N channels.
package arb_mux_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N     = 4;

    // Bits needed to index n channels, never less than one.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Grant selection for arb_mux: round-robin from a pointer, or fixed priority.
// The pointer remembers the last granted channel so it gets lowest priority next.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter  int N    = DEFAULT_N,
    parameter  int RR   = 1,
    localparam int SELW = sel_width(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt_onehot,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] ptr_r;
    logic [SELW-1:0] gnt_idx_s;
    logic            found_s;

    // Priority search: first requester at or after base, wrapping modulo N
    always_comb begin
        int   base_s;
        int   idx_s;
        logic hit_s;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        idx_s     = 0;
        hit_s     = 1'b0;
        base_s    = (RR != 0) ? (int'(ptr_r) + 1) : 0;
        for (int k = 0; k < N; k++) begin
            idx_s     = (base_s + k) % N;
            hit_s     = req[idx_s[SELW-1:0]] & ~found_s;
            gnt_idx_s = hit_s ? idx_s[SELW-1:0] : gnt_idx_s;
            found_s   = found_s | hit_s;
        end
    end

    assign gnt_idx    = gnt_idx_s;
    assign gnt_onehot = found_s ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx_s) : {N{1'b0}};

    // Pointer follows the winner only when the grant is actually taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= SELW'(N - 1);
        end else if (advance && (RR != 0)) begin
            ptr_r <= gnt_idx_s;
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with a one-entry registered output stage.
// The stage refills in the same cycle it drains, so throughput is one word per cycle.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = DEFAULT_N,
    parameter  int RR    = 1,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
);

    logic             can_accept_s;
    logic             in_xfer_s;
    logic [N-1:0]     gnt_onehot_s;
    logic [SELW-1:0]  gnt_idx_s;
    logic [WIDTH-1:0] sel_data_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_sel_r;

    rr_arbiter #(
        .N  (N),
        .RR (RR)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (in_valid),
        .advance    (in_xfer_s),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s)
    );

    assign can_accept_s = ~out_valid_r | out_ready;
    assign in_ready     = can_accept_s ? gnt_onehot_s : {N{1'b0}};
    assign in_xfer_s    = can_accept_s & (|gnt_onehot_s);
    assign sel_data_s   = in_data[int'(gnt_idx_s) * WIDTH +: WIDTH];

    // Output stage: load on accept, empty on drain, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SELW{1'b0}};
        end else if (in_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= sel_data_s;
            out_sel_r   <= gnt_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: a round-robin and a fixed-priority instance share stimulus
// and are checked against a distance-based priority model.
module tb_arb_mux;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] data;
        int           sel;
    } item_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic           out_ready = 1'b0;

    logic [N-1:0] in_ready0, in_ready1;
    logic         out_valid0, out_valid1;
    logic [W-1:0] out_data0, out_data1;
    logic [1:0]   out_sel0, out_sel1;

    item_t        q_rr[$];
    item_t        q_fp[$];
    int           checks = 0;
    int           failures = 0;
    int           m_ptr = N - 1;
    bit           m_valid[2];
    logic [N-1:0] last_rdy[2];

    arb_mux #(.WIDTH(W), .N(N), .RR(1)) dut_rr (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_sel(out_sel0)
    );

    arb_mux #(.WIDTH(W), .N(N), .RR(0)) dut_fp (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_sel(out_sel1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Winner = valid channel closest after the last winner (rr), or lowest index (fixed).
    function automatic int model_grant(input logic [N-1:0] v, input int ptr, input bit rr);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N + 1;
        for (int i = 0; i < N; i++) begin
            d = rr ? ((i - ptr - 1 + 2 * N) % N) : i;
            if (v[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic model_cycle(input logic [N-1:0] v, input logic r, input logic [N*W-1:0] d);
        for (int k = 0; k < 2; k++) begin
            int           g;
            bit           can;
            logic [N-1:0] exp_rdy;
            item_t        it;
            g       = model_grant(v, m_ptr, k == 0);
            can     = !m_valid[k] || r;
            exp_rdy = '0;
            if (can && g >= 0) exp_rdy[g] = 1'b1;
            if (k == 0) begin
                last_rdy[0] = in_ready0;
                chk("in_ready_rr", in_ready0, exp_rdy);
            end else begin
                last_rdy[1] = in_ready1;
                chk("in_ready_fp", in_ready1, exp_rdy);
            end
            if (can && g >= 0) begin
                it.data = d[g*W +: W];
                it.sel  = g;
                if (k == 0) begin
                    q_rr.push_back(it);
                    m_ptr = g;
                end else begin
                    q_fp.push_back(it);
                end
                m_valid[k] = 1'b1;
            end else if (r) begin
                m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic model_clear();
        m_ptr      = N - 1;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        q_rr.delete();
        q_fp.delete();
    endtask

    // Drive after the edge, settle, then compare in_ready and update the model.
    task automatic step(input logic [N-1:0] v, input logic r, input logic [N*W-1:0] d);
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        #6;
        model_cycle(v, r, d);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: held word must match the scoreboard head when the consumer takes it
    always @(negedge clk) begin
        if (!reset) begin
            item_t it;
            chk("out_valid_rr", out_valid0, q_rr.size() != 0);
            chk("out_valid_fp", out_valid1, q_fp.size() != 0);
            if (out_valid0 && out_ready && q_rr.size() != 0) begin
                it = q_rr.pop_front();
                chk("out_data_rr", out_data0, it.data);
                chk("out_sel_rr", out_sel0, it.sel);
            end
            if (out_valid1 && out_ready && q_fp.size() != 0) begin
                it = q_fp.pop_front();
                chk("out_data_fp", out_data1, it.data);
                chk("out_sel_fp", out_sel1, it.sel);
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;

        do_reset();
        chk("reset_valid", out_valid0, 1'b0);
        chk("reset_data", out_data0, 32'h0);
        chk("reset_sel", out_sel0, 2'd0);

        // Single requester on channel 2
        d = rnd_data();
        d[2*W +: W] = 32'hDEADBEEF;
        step(4'b0100, 1'b1, d);
        chk("ch2_in_ready", last_rdy[0], 4'b0100);
        step(4'b0000, 1'b1, rnd_data());
        chk("ch2_out_valid", out_valid0, 1'b1);
        chk("ch2_out_data", out_data0, 32'hDEADBEEF);
        chk("ch2_out_sel", out_sel0, 2'd2);

        // Round-robin order with everyone requesting
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b1, rnd_data());
            chk("rr_grant", last_rdy[0], 4'b0001 << (i % 4));
            if (i > 0) chk("rr_out_sel", out_sel0, (i - 1) % 4);
        end

        // Backpressure holds the word and the pointer
        do_reset();
        d = rnd_data();
        d[0 +: W] = 32'h11111111;
        step(4'b0001, 1'b1, d);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, rnd_data());
            chk("stall_in_ready", last_rdy[0], 4'b0000);
            chk("stall_data", out_data0, 32'h11111111);
        end
        step(4'b1111, 1'b1, rnd_data());
        chk("stall_release_grant", last_rdy[0], 4'b0010);
        step(4'b0000, 1'b1, rnd_data());
        chk("stall_release_sel", out_sel0, 2'd1);

        // Fixed priority: channel 1 always beats channel 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(4'b1010, 1'b1, rnd_data());
            chk("fp_grant", last_rdy[1], 4'b0010);
        end

        // Asynchronous reset while a word is stalled
        do_reset();
        step(4'b1111, 1'b0, rnd_data());
        step(4'b1111, 1'b0, rnd_data());
        chk("pre_areset_valid", out_valid0, 1'b1);
        reset    = 1'b1;
        in_valid = '0;
        #1;
        chk("areset_valid", out_valid0, 1'b0);
        chk("areset_data", out_data0, 32'h0);
        chk("areset_sel", out_sel0, 2'd0);
        chk("areset_valid_fp", out_valid1, 1'b0);
        model_clear();
        #1 reset = 1'b0;
        step(4'b1111, 1'b1, rnd_data());
        chk("post_areset_grant", last_rdy[0], 4'b0001);

        // Idle cycles do not rotate the pointer
        do_reset();
        step(4'b0010, 1'b1, rnd_data());
        repeat (3) step(4'b0000, 1'b1, rnd_data());
        step(4'b1111, 1'b1, rnd_data());
        chk("idle_grant", last_rdy[0], 4'b0100);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), rnd_data());
        end
        repeat (3) step(4'b0000, 1'b1, rnd_data());
        chk("drain_rr", q_rr.size(), 0);
        chk("drain_fp", q_fp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
